led_pattern_seq: RTL and testbench

- Parametrised successor to the team's 16-LED chaser: drives N LEDs through four step patterns, each step lasting TICK_DIV clocks.
- Patterns: shift right, shift left, inside-to-outside, outside-to-inside.
- Adds step enable/pause, auto-cycle vs fixed-pattern mode, step/wrap pulses, and an optional PWM brightness stage.
- Sits between the board clock and the LED pins.

---
 rtl/led_pattern_seq.sv | 138 +++++++++++++
 tb/tb_led_pattern_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps N LEDs through four patterns (shift right, shift left,
// inside-out, outside-in), one step every TICK_DIV clocks. Optional PWM dimming via LED_PWM_EN.
module led_pattern_seq #(
  parameter int N        = 16,
  parameter int TICK_DIV = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         auto,
  input  logic [1:0]   sel_pat,
`ifdef LED_PWM_EN
  input  logic [3:0]   duty,
`endif
  output logic [N-1:0] light,
  output logic [1:0]   state,
  output logic         step,
  output logic         wrap
);

  localparam int H       = N / 2;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W   = $clog2(N);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]   LAST_FULL = POS_W'(N - 1);
  localparam logic [POS_W-1:0]   LAST_HALF = POS_W'(H - 1);
  localparam logic [N-1:0]       LIGHT_RST = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_R  = 2'b00,
    S_L  = 2'b01,
    S_IO = 2'b11,
    S_OI = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [N-1:0]       light_reg, light_next, pat_next;
  logic               step_reg, step_next;
  logic               wrap_reg, wrap_next;
  logic               tick;
  logic               pos_last;

  assign tick     = en && (presc_reg == PRESC_MAX);
  assign pos_last = (state_reg == S_R || state_reg == S_L) ? (pos_reg == LAST_FULL)
                                                          : (pos_reg == LAST_HALF);

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    presc_next = presc_reg;
    step_next  = tick;
    wrap_next  = 1'b0;
    if (en) begin
      presc_next = tick ? '0 : presc_reg + PRESC_W'(1);
    end
    if (tick) begin
      if (pos_last) begin
        pos_next  = '0;
        wrap_next = 1'b1;
        if (auto) begin
          unique case (state_reg)
            S_R:     state_next = S_L;
            S_L:     state_next = S_IO;
            S_IO:    state_next = S_OI;
            default: state_next = S_R;
          endcase
        end else begin
          state_next = state_t'(sel_pat);
        end
      end else begin
        pos_next = pos_reg + POS_W'(1);
      end
    end
  end

  // Decode the pattern from the *next* state/pos so light lands on the same edge as state.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      if (gi >= H) begin : g_hi
        assign pat_next[gi] = (state_next == S_R  && pos_next == POS_W'(N - 1 - gi)) ||
                              (state_next == S_L  && pos_next == POS_W'(gi))         ||
                              (state_next == S_IO && pos_next == POS_W'(gi - H))     ||
                              (state_next == S_OI && pos_next == POS_W'(N - 1 - gi));
      end else begin : g_lo
        assign pat_next[gi] = (state_next == S_R  && pos_next == POS_W'(N - 1 - gi)) ||
                              (state_next == S_L  && pos_next == POS_W'(gi))         ||
                              (state_next == S_IO && pos_next == POS_W'(H - 1 - gi)) ||
                              (state_next == S_OI && pos_next == POS_W'(gi));
      end
    end
  endgenerate

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_reg, pwm_cnt_next;
  assign pwm_cnt_next = pwm_cnt_reg + 4'd1;
  assign light_next   = pat_next & {N{pwm_cnt_next < duty}};

  always_ff @(posedge clk) begin
    if (!rst) pwm_cnt_reg <= '0;
    else      pwm_cnt_reg <= pwm_cnt_next;
  end
`else
  assign light_next = pat_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_R;
      pos_reg   <= '0;
      presc_reg <= '0;
      step_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
`ifdef LED_PWM_EN
      // pwm_cnt restarts at 0, so the gate is open for any nonzero duty.
      light_reg <= LIGHT_RST & {N{duty != 4'd0}};
`else
      light_reg <= LIGHT_RST;
`endif
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      presc_reg <= presc_next;
      step_reg  <= step_next;
      wrap_reg  <= wrap_next;
      light_reg <= light_next;
    end
  end

  assign light = light_reg;
  assign state = state_reg;
  assign step  = step_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq: table of hand vectors plus a scoreboarded reference model,
// with a second TICK_DIV=1 instance for single-clock stepping (and PWM when LED_PWM_EN is set).
module tb_led_pattern_seq;
  localparam int N  = 16;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, auto_mode;
  logic [1:0]  sel_pat;
  logic [15:0] light;
  logic [1:0]  state;
  logic        step, wrap;

  logic        rst1, en1, auto1;
  logic [15:0] light1;
  logic [1:0]  state1;
  logic        step1, wrap1;
`ifdef LED_PWM_EN
  logic [3:0]  duty, duty1;
`endif

  led_pattern_seq #(.N(N), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .en(en), .auto(auto_mode), .sel_pat(sel_pat),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .light(light), .state(state), .step(step), .wrap(wrap)
  );

  led_pattern_seq #(.N(N), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .auto(auto1), .sel_pat(2'b00),
`ifdef LED_PWM_EN
    .duty(duty1),
`endif
    .light(light1), .state(state1), .step(step1), .wrap(wrap1)
  );

  typedef struct packed {
    logic [15:0] light;
    logic [1:0]  state;
    logic        step;
    logic        wrap;
  } obs_t;

  typedef struct {
    logic r, e, a;
    logic [1:0]  s;
    logic [15:0] light;
    logic [1:0]  state;
    logic        step, wrap;
  } vec_t;

  int vectors = 0, miscompares = 0;
  obs_t sb[$];
  obs_t got;

  // Reference model state
  logic [1:0] m_state;
  int m_pos, m_presc, ticks, dut_wraps;
  logic m_step, m_wrap;
`ifdef LED_PWM_EN
  logic [3:0] m_pwm;
`endif

  function automatic logic [15:0] raw_pat(input logic [1:0] s, input int p);
    logic [15:0] one = 16'h0001;
    case (s)
      2'b00:   return one << (15 - p);
      2'b01:   return one << p;
      2'b11:   return (one << (8 + p)) | (one << (7 - p));
      default: return (one << (15 - p)) | (one << p);
    endcase
  endfunction

  function automatic logic [15:0] gated(input logic [15:0] x);
`ifdef LED_PWM_EN
    return (m_pwm < duty) ? x : 16'h0000;
`else
    return x;
`endif
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic a, input logic [1:0] s);
    logic t;
    int len;
    if (!r) begin
      m_state = 2'b00; m_pos = 0; m_presc = 0; m_step = 0; m_wrap = 0;
`ifdef LED_PWM_EN
      m_pwm = 4'd0;
`endif
    end else begin
`ifdef LED_PWM_EN
      m_pwm = m_pwm + 4'd1;
`endif
      t = e && (m_presc == TD - 1);
      m_step = t;
      m_wrap = 1'b0;
      if (e) m_presc = t ? 0 : m_presc + 1;
      if (t) begin
        ticks++;
        len = (m_state == 2'b00 || m_state == 2'b01) ? 16 : 8;
        if (m_pos == len - 1) begin
          m_pos = 0;
          m_wrap = 1'b1;
          if (a) begin
            case (m_state)
              2'b00:   m_state = 2'b01;
              2'b01:   m_state = 2'b11;
              2'b11:   m_state = 2'b10;
              default: m_state = 2'b00;
            endcase
          end else begin
            m_state = s;
          end
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got light=%h state=%b step=%b wrap=%b, expected light=%h state=%b step=%b wrap=%b",
               name, act.light, act.state, act.step, act.wrap, exp.light, exp.state, exp.step, exp.wrap);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one clock of stimulus; expectation is queued at drive time, popped at the sample point.
  task automatic apply(input string name, input logic r, input logic e, input logic a,
                       input logic [1:0] s, output obs_t o);
    obs_t exp;
    rst = r; en = e; auto_mode = a; sel_pat = s;
    model_edge(r, e, a, s);
    sb.push_back('{gated(raw_pat(m_state, m_pos)), m_state, m_step, m_wrap});
    @(posedge clk);
    @(negedge clk);
    o = '{light, state, step, wrap};
    if (wrap) dut_wraps++;
    exp = sb.pop_front();
    check_obs(name, o, exp);
    $display("[%s] rst=%b en=%b auto=%b sel=%b -> light=%h state=%b step=%b wrap=%b",
             name, r, e, a, s, light, state, step, wrap);
  endtask

  task automatic run_steps(input string name, input int n, input logic a,
                           input logic [1:0] s, output obs_t o);
    int start = ticks;
    int budget = n * TD + TD + 2;
    o = '0;
    while ((ticks - start) < n && budget > 0) begin
      apply(name, 1'b1, 1'b1, a, s, o);
      budget--;
    end
    if ((ticks - start) < n) check_int({name, "_budget"}, ticks - start, n);
  endtask

  vec_t tbl[8];
  logic [15:0] wrap_light[4];
  logic [1:0]  wrap_state[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, guard;
    obs_t exp1;
    rst = 1'b0; en = 1'b1; auto_mode = 1'b1; sel_pat = 2'b00;
    rst1 = 1'b0; en1 = 1'b0; auto1 = 1'b1;
`ifdef LED_PWM_EN
    duty = 4'd15; duty1 = 4'd8; m_pwm = 4'd0;
`endif
    m_state = 2'b00; m_pos = 0; m_presc = 0; m_step = 0; m_wrap = 0;
    ticks = 0; dut_wraps = 0;

    // rst, en, auto, sel, expected light, state, step, wrap
    tbl[0] = '{1'b0, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 2'b00, 16'h8000, 2'b00, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'b00, 16'h4000, 2'b00, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b00, 16'h4000, 2'b00, 1'b0, 1'b0};
    wrap_light = '{16'h0001, 16'h0180, 16'h8001, 16'h8000};
    wrap_state = '{2'b01, 2'b11, 2'b10, 2'b00};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply("reset_tbl", tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].s, got);
      check_obs("reset_tbl_hand", got, '{gated(tbl[i].light), tbl[i].state, tbl[i].step, tbl[i].wrap});
    end

    // Full auto cycle: 16+16+8+8 steps, one already taken
    wi = 0; dut_wraps = 0; guard = 0;
    while (ticks < 48 && guard < 48 * TD + 8) begin
      apply("sweep", 1'b1, 1'b1, 1'b1, 2'b00, got);
      guard++;
      if (got.wrap && wi < 4) begin
        check_obs("sweep_wrap_hand", got, '{gated(wrap_light[wi]), wrap_state[wi], 1'b1, 1'b1});
        wi++;
      end
    end
    check_int("sweep_done", ticks, 48);
    check_int("wrap_count", dut_wraps, 4);

    // Pause with prescaler at 2
    apply("pause_pre", 1'b1, 1'b1, 1'b1, 2'b00, got);
    apply("pause_pre", 1'b1, 1'b1, 1'b1, 2'b00, got);
    for (int i = 0; i < 10; i++) begin
      apply("pause", 1'b1, 1'b0, 1'b1, 2'b00, got);
      check_obs("pause_hold_hand", got, '{gated(16'h8000), 2'b00, 1'b0, 1'b0});
    end
    apply("resume", 1'b1, 1'b1, 1'b1, 2'b00, got);
    check_obs("resume1_hand", got, '{gated(16'h8000), 2'b00, 1'b0, 1'b0});
    apply("resume", 1'b1, 1'b1, 1'b1, 2'b00, got);
    check_obs("resume2_hand", got, '{gated(16'h4000), 2'b00, 1'b1, 1'b0});

    // Fixed mode: S_R finishes into S_IO, sel_pat change mid-S_IO only takes effect at its wrap
    run_steps("fixed_r", 15, 1'b0, 2'b11, got);
    check_obs("fixed_enter_io", got, '{gated(16'h0180), 2'b11, 1'b1, 1'b1});
    run_steps("fixed_io", 3, 1'b0, 2'b11, got);
    run_steps("fixed_io_sel", 4, 1'b0, 2'b01, got);
    check_obs("fixed_io_end", got, '{gated(16'h8001), 2'b11, 1'b1, 1'b0});
    run_steps("fixed_io_sel", 1, 1'b0, 2'b01, got);
    check_obs("fixed_enter_l", got, '{gated(16'h0001), 2'b01, 1'b1, 1'b1});
    run_steps("fixed_l", 16, 1'b0, 2'b01, got);
    check_obs("fixed_repeat_l", got, '{gated(16'h0001), 2'b01, 1'b1, 1'b1});

    // Reset in the middle of S_OI
    run_steps("to_oi", 16, 1'b0, 2'b10, got);
    check_obs("enter_oi", got, '{gated(16'h8001), 2'b10, 1'b1, 1'b1});
    run_steps("oi", 3, 1'b0, 2'b10, got);
    check_obs("oi_pos3", got, '{gated(16'h1008), 2'b10, 1'b1, 1'b0});
    apply("oi", 1'b1, 1'b1, 1'b0, 2'b10, got);
    apply("mid_reset", 1'b0, 1'b1, 1'b0, 2'b10, got);
    check_obs("mid_reset_hand", got, '{gated(16'h8000), 2'b00, 1'b0, 1'b0});

    // TICK_DIV=1 instance: one step per clock
    rst1 = 1'b1; en1 = 1'b1; auto1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      logic [15:0] raw;
      logic [15:0] one;
      one = 16'h0001;
      raw = (k < 16) ? (16'h8000 >> k) : (one << (k - 16));
`ifdef LED_PWM_EN
      if ((k % 16) >= 8) raw = 16'h0000;
`endif
      sb.push_back('{raw, (k < 16) ? 2'b00 : 2'b01, 1'b1, (k == 16)});
      @(posedge clk);
      @(negedge clk);
      exp1 = sb.pop_front();
      check_obs("div1", '{light1, state1, step1, wrap1}, exp1);
      $display("[div1] k=%0d light=%h state=%b step=%b wrap=%b", k, light1, state1, step1, wrap1);
    end
`ifdef LED_PWM_EN
    duty1 = 4'd0;
    for (int k = 0; k < 16; k++) begin
      sb.push_back('{16'h0000, state1, 1'b1, 1'b0});
      @(posedge clk);
      @(negedge clk);
      exp1 = sb.pop_front();
      check_int("duty0_dark", int'(light1), int'(exp1.light));
      $display("[duty0] light=%h", light1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
